// File: rtl/mem_responder_if.sv
// Request/response bundle between the control sequencer (master) and the
// wait-state memory responder (slave).
interface mem_responder_if #(
   parameter int BITS      = 32,
   parameter int ADDR_BITS = 9
);
   logic                 Read;
   logic                 Write;
   logic [ADDR_BITS-1:0] address;
   logic [BITS-1:0]      wrData;
   logic [BITS-1:0]      rdData;
   logic                 Done;
   logic                 Busy;
   logic                 Error;

   modport master (
      output Read, Write, address, wrData,
      input  rdData, Done, Busy, Error
   );

   modport slave (
      input  Read, Write, address, wrData,
      output rdData, Done, Busy, Error
   );
endinterface

// File: rtl/mem_responder.sv
// Slow memory stand-in: latches a request, inserts WAIT_CYCLES wait states,
// performs one RAM access and holds Done until both strobes are released.
//
// state  | meaning
// IDLE   | waiting for exactly one strobe; both high flags Error
// WAIT   | counting down wait states
// ACCESS | single-cycle RAM read or write at the latched address
// DONE   | Done held until Read and Write are both low
module mem_responder #(
   parameter int BITS        = 32,
   parameter int RAMSIZE     = 512,
   parameter int ADDR_BITS   = 9,
   parameter int WAIT_CYCLES = 1
) (
   input logic             clk,
   input logic             reset,
   mem_responder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [BITS-1:0]      wdata_q, wdata_d;
   logic [BITS-1:0]      rdata_q, rdata_d;
   logic                 op_wr_q, op_wr_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic                 mem_we;

   logic [BITS-1:0]      mem_q [RAMSIZE];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      op_wr_d = op_wr_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.Read && bus.Write) begin
               err_d = 1'b1;
            end else if (bus.Read || bus.Write) begin
               addr_d  = bus.address;
               wdata_d = bus.wrData;
               op_wr_d = bus.Write;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (op_wr_q) begin
               mem_we = 1'b1;
            end else begin
               rdata_d = mem_q[addr_q];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!bus.Read && !bus.Write) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered copies of the next-state decode.
      done_d = (state_d == S_DONE);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         op_wr_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         op_wr_q <= op_wr_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // RAM is never cleared; a write landing on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign bus.rdData = rdata_q;
   assign bus.Done   = done_q;
   assign bus.Busy   = busy_q;
   assign bus.Error  = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Runs four responders (WAIT_CYCLES 0..3) in lockstep from one request
// stream; per-instance monitors check completions against a scoreboard.
module tb_mem_responder;

   typedef struct {
      bit          is_wr;
      logic [31:0] data;
      int          e0;
      bit          early;
   } txn_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_s, wr_s;
   logic [8:0]  addr_s;
   logic [31:0] wdata_s;

   logic [31:0] rd_v   [4];
   logic        done_v [4];
   logic        busy_v [4];
   logic        err_v  [4];

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          rd_idx [4];

   txn_t        txn [$];
   logic [31:0] mdl [logic [8:0]];
   logic [8:0]  pool [$];

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g_dut
      mem_responder_if #(.BITS(32), .ADDR_BITS(9)) bus ();

      assign bus.Read    = rd_s;
      assign bus.Write   = wr_s;
      assign bus.address = addr_s;
      assign bus.wrData  = wdata_s;
      assign rd_v[k]     = bus.rdData;
      assign done_v[k]   = bus.Done;
      assign busy_v[k]   = bus.Busy;
      assign err_v[k]    = bus.Error;

      mem_responder #(
         .BITS(32), .RAMSIZE(512), .ADDR_BITS(9), .WAIT_CYCLES(k)
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      logic        prev_done = 1'b0;
      bit          early_cur = 1'b0;
      int          dlen      = 0;
      logic [31:0] last_rd   = '0;

      // A reset edge aborts whatever is outstanding for this instance.
      initial forever begin
         @(posedge clk);
         if (reset) begin
            rd_idx[k] = txn.size();
            last_rd   = '0;
            prev_done = 1'b0;
            early_cur = 1'b0;
         end
      end

      initial forever begin
         txn_t t;
         @(negedge clk);
         if (!reset) begin
            if (done_v[k] && !prev_done) begin
               check($sformatf("w%0d_unexpected_done", k), 32'(rd_idx[k] < txn.size()), 32'd1);
               if (rd_idx[k] < txn.size()) begin
                  t = txn[rd_idx[k]];
                  rd_idx[k]++;
                  check($sformatf("w%0d_latency", k), cyc, t.e0 + k + 1);
                  if (!t.is_wr) last_rd = t.data;
                  check($sformatf("w%0d_rdData", k), rd_v[k], last_rd);
                  early_cur = t.early;
                  dlen      = 1;
               end
            end else if (done_v[k]) begin
               dlen++;
            end else if (prev_done && early_cur) begin
               check($sformatf("w%0d_early_done_len", k), dlen, 1);
            end
            prev_done = done_v[k];
         end
      end
   end

   function automatic bit all_done();
      bit r = 1'b1;
      for (int i = 0; i < 4; i++) r &= done_v[i];
      return r;
   endfunction

   function automatic bit any_done();
      bit r = 1'b0;
      for (int i = 0; i < 4; i++) r |= done_v[i];
      return r;
   endfunction

   function automatic bit all_busy();
      bit r = 1'b1;
      for (int i = 0; i < 4; i++) r &= busy_v[i];
      return r;
   endfunction

   function automatic bit any_busy();
      bit r = 1'b0;
      for (int i = 0; i < 4; i++) r |= busy_v[i];
      return r;
   endfunction

   task automatic check_idle_all(string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_w%0d_rdData", tag, i), rd_v[i], 32'd0);
         check($sformatf("%s_w%0d_Done", tag, i), 32'(done_v[i]), 32'd0);
         check($sformatf("%s_w%0d_Busy", tag, i), 32'(busy_v[i]), 32'd0);
         check($sformatf("%s_w%0d_Error", tag, i), 32'(err_v[i]), 32'd0);
      end
   endtask

   // Called and returns at a negedge with all instances idle.
   task automatic do_op(bit wr, logic [8:0] a, logic [31:0] d, bit early, int hold);
      txn_t t;
      int   n;
      rd_s    = !wr;
      wr_s    = wr;
      addr_s  = a;
      wdata_s = d;
      t.is_wr = wr;
      t.data  = wr ? 32'd0 : mdl[a];
      t.e0    = cyc + 1;
      t.early = early;
      txn.push_back(t);
      if (wr) begin
         if (!mdl.exists(a)) pool.push_back(a);
         mdl[a] = d;
      end
      @(negedge clk);
      check("busy_after_E0", 32'(all_busy()), 32'd1);
      addr_s  = 9'($urandom);
      wdata_s = $urandom;
      if (early) begin
         rd_s = 1'b0;
         wr_s = 1'b0;
         n = 0;
         while (any_busy() && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("idle_timeout", 32'(any_busy()), 32'd0);
      end else begin
         n = 0;
         while (!all_done() && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("done_timeout", 32'(all_done()), 32'd1);
         repeat (hold) begin
            @(negedge clk);
            check("done_held", 32'(all_done()), 32'd1);
         end
         rd_s = 1'b0;
         wr_s = 1'b0;
         @(negedge clk);
         check("done_release", 32'(any_done()), 32'd0);
         check("busy_release", 32'(any_busy()), 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      rd_s    = 1'($urandom);
      wr_s    = 1'($urandom);
      addr_s  = 9'($urandom);
      wdata_s = $urandom;
      @(negedge clk);
      check_idle_all("reset1");
      rd_s = 1'($urandom);
      wr_s = 1'($urandom);
      @(negedge clk);
      check_idle_all("reset2");
      reset = 1'b0;
      rd_s  = 1'b0;
      wr_s  = 1'b0;
      @(negedge clk);

      do_op(1'b1, 9'h000, 32'h0000_0000, 1'b0, 0);
      do_op(1'b1, 9'h010, 32'h0000_FFFF, 1'b0, 0);

      do_op(1'b1, 9'h005, 32'h0000_00A5, 1'b0, 0);
      do_op(1'b0, 9'h005, 32'h0,         1'b0, 0);

      do_op(1'b1, 9'h1FF, 32'hDEAD_BEEF, 1'b0, 0);
      do_op(1'b0, 9'h1FF, 32'h0,         1'b0, 0);
      do_op(1'b0, 9'h000, 32'h0,         1'b0, 0);

      // Both strobes high in IDLE: flagged, no access.
      rd_s    = 1'b1;
      wr_s    = 1'b1;
      addr_s  = 9'h005;
      wdata_s = 32'hBAD0_BAD0;
      repeat (3) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            check($sformatf("both_w%0d_Error", i), 32'(err_v[i]), 32'd1);
            check($sformatf("both_w%0d_Busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("both_w%0d_Done", i), 32'(done_v[i]), 32'd0);
         end
      end
      rd_s = 1'b0;
      wr_s = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         check($sformatf("both_w%0d_Error_clear", i), 32'(err_v[i]), 32'd0);
      do_op(1'b0, 9'h005, 32'h0, 1'b0, 0);

      // Reset lands one edge after the write is sampled: write must be lost.
      wr_s    = 1'b1;
      addr_s  = 9'h010;
      wdata_s = 32'h1234_5678;
      @(negedge clk);
      check("abort_busy", 32'(all_busy()), 32'd1);
      reset = 1'b1;
      wr_s  = 1'b0;
      @(negedge clk);
      check_idle_all("abort");
      reset = 1'b0;
      @(negedge clk);
      do_op(1'b0, 9'h010, 32'h0, 1'b0, 0);

      do_op(1'b0, 9'h1FF, 32'h0, 1'b0, 5);
      do_op(1'b0, 9'h005, 32'h0, 1'b1, 0);
      do_op(1'b1, 9'h020, 32'hCAFE_F00D, 1'b1, 0);
      do_op(1'b0, 9'h020, 32'h0, 1'b0, 0);

      for (int n = 0; n < 40; n++) begin
         bit         wr = ($urandom_range(0, 2) == 0);
         logic [8:0] a;
         if (wr) a = 9'($urandom);
         else    a = pool[$urandom_range(0, pool.size() - 1)];
         do_op(wr, a, $urandom, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      end

      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++)
         check($sformatf("w%0d_all_consumed", i), rd_idx[i], txn.size());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the datapath's Read/Write memory strobes. It latches an address and write data on a request, waits a programmable number of cycles, performs one access on an internal RAMSIZE-word array, and holds `Done` until the requester releases its strobe (four-phase handshake). It stands in for the slow memory behind MAR/MDR so the control sequencer can be tested against realistic wait states.

## Interface
Parameters:
- `BITS`, 32, data word width
- `RAMSIZE`, 512, number of words
- `ADDR_BITS`, 9, address width; must equal log2(RAMSIZE)
- `WAIT_CYCLES`, 1, wait states before the access; legal range 0..15

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; clears control state only
- `Read`  in  1  read request strobe
- `Write`  in  1  write request strobe
- `address`  in  ADDR_BITS  word address (MARVal low bits)
- `wrData`  in  BITS  write data (MDRVal)
- `rdData`  out  BITS  read data; valid while `Done` is high after a read
- `Done`  out  1  access complete; held until both strobes are low
- `Busy`  out  1  high whenever the FSM is not in IDLE
- `Error`  out  1  high while `Read` and `Write` are sampled together in IDLE

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE. All outputs are registered.
- **Reset:** state becomes IDLE. `rdData`=0, `Done`=0, `Busy`=0, `Error`=0, wait counter=0. RAM contents are not cleared.
- **IDLE, exactly one of `Read`/`Write` high:**
  - Latch `address`, `wrData` and the op.
  - Go to WAIT with the counter loaded to `WAIT_CYCLES`; if `WAIT_CYCLES`=0, go straight to ACCESS.
- **IDLE, both strobes high:** no latch, stay in IDLE, `Error`=1. `Error` returns to 0 on the first edge where both are not high.
- **WAIT:** decrement the counter each edge. On the edge where the counter equals 1, go to ACCESS.
- **ACCESS:** lasts one cycle.
  - Write: `mem[addr_latched]` ← `wr_latched` at the closing edge.
  - Read: `rdData` ← `mem[addr_latched]` at the closing edge.
  - Then go to DONE.
- **DONE:** `Done`=1. Stay in DONE while `Read` or `Write` is high. Go to IDLE on the first edge where both are low; `Done` clears on that edge.
- Input changes after the sampling edge (address, data, strobe level) are ignored until the FSM is back in IDLE.
- A strobe dropped early (during WAIT or ACCESS) does not cancel the access. The access completes, DONE lasts exactly one cycle, then the FSM returns to IDLE.
- `rdData` holds the last completed read value; writes never change it.
- Read-after-write to the same address returns the new data.
- **Reset mid-operation:** from any state, go to IDLE and clear the outputs. A write whose ACCESS closing edge coincides with reset asserted is not performed.
- Address is exactly ADDR_BITS wide, so there is no out-of-range case; 0x1FF and 0x000 are distinct words.

## Timing
- Request sampled at edge E0. `Done` and read data are visible after edge E0+W+1, where W=`WAIT_CYCLES`.
  - W=0: `Done` after E1.
  - W=1: `Done` after E2.
- `Busy` rises after E0 and falls on the edge that enters IDLE.
- Minimum turnaround: both strobes low for at least one sampling edge while in DONE. The next request can be sampled on the edge after IDLE is entered.
- Throughput: one access per W+3 cycles with immediate strobe release.
- `Error` asserts one edge after both strobes are seen high in IDLE.

## Test plan
1. Assert `reset` for 2 cycles with random strobes → `rdData`=0, `Done`=0, `Busy`=0, `Error`=0 after the first reset edge.
2. W=2: Write addr 0x005 data 0x000000A5, sampled at E0 → `Busy` high after E0, `Done` high after E3. Release the strobe, then Read 0x005 → `rdData`=0x000000A5 with `Done` after E3 of the read.
3. W=0: Write 0x1FF data 0xDEADBEEF, then Read 0x1FF, then Read 0x000 → 0xDEADBEEF and then 0x00000000 (0x000 previously written 0). `Done` one edge after each sample.
4. `Read`=`Write`=1 for 3 cycles in IDLE → `Error`=1 for those cycles, `Busy`=0, `Done`=0. A later Read of the test address shows the memory unchanged.
5. W=3: Write 0x010 data 0x12345678 (0x010 previously holds 0x0000FFFF), with `reset` pulsed during WAIT → FSM in IDLE, outputs 0. A later Read 0x010 returns 0x0000FFFF.
6. Four-phase check: hold `Read` 5 cycles past `Done` → `Done` stays 1, single access. Change `address` during WAIT → the original address is used. Drop the strobe during WAIT → `Done` pulses for exactly one cycle.
